ternary_branch_resolver: RTL and testbench
==========================================

// Module: ternary_branch_resolver
// PURPOSE
//  Tracks in-flight predicted branches from decode to execute; checks each prediction against the actual outcome.
//  On mispredict: squashes younger in-flight entries and issues a one-cycle redirect and flush to fetch.
//  Fed by ternary_branch_predictor (predict_taken) and the decoder (pc, 2-trit imm); consumed by the fetch PC mux.
// PARAMETERS
//  DEPTH  4   in-flight branch queue entries; power of two, >= 2
//  PC_W   16  binary PC width
// PORTS
//  clk                input   1          single clock, rising edge
//  rst                input   1          synchronous, active-high reset
//  dec_valid          input   1          decode presents a branch this cycle
//  dec_pc             input   PC_W       PC of that branch
//  dec_offset         input   trit_t[1:0] 2-trit balanced-ternary offset, [1] weight 3, [0] weight 1
//  dec_predict_taken  input   1          predictor output for that branch
//  dec_ready          output  1          queue accepts a push this cycle
//  ex_valid           input   1          execute resolves the OLDEST in-flight branch
//  ex_actual_taken    input   1          actual outcome of that branch
//  redirect_valid     output  1          one-cycle pulse: fetch must load redirect_pc
//  redirect_pc        output  PC_W       corrected fetch PC
//  flush              output  1          one-cycle pulse: squash wrong-path instrs in fetch/decode
//  inflight_count     output  $clog2(DEPTH+1)  number of queued entries
// BEHAVIOUR
//  Reset: queue empty, rd/wr ptrs 0, inflight_count=0, redirect_valid=0, flush=0, redirect_pc=0.
//  Push: dec_valid && dec_ready stores {pc, offset, predict_taken} at wr ptr.
//  dec_ready = !full && !flush; a dec_valid while dec_ready=0 is dropped silently.
//  Pop: ex_valid && !empty resolves the head entry. ex_valid while empty is ignored (no state change).
//  Same-cycle push and pop are allowed unless full; full blocks push even with a pop (no bypass).
//  Offset decode: T_NEG_ONE=-1, T_ZERO=0, T_POS_ONE=+1. Illegal trit encoding decodes as 0.
//  Offset value = 3*t1 + t0, range -4..+4.
//  Targets are mod 2^PC_W, wrap permitted:
//   taken_tgt = pc + sext(offset)
//   fall_tgt  = pc + 1
//  Mispredict = head.predict_taken != ex_actual_taken.
//  Mispredict at resolve cycle N, at edge N->N+1:
//   - queue cleared (ptrs 0, count 0); a same-cycle push is discarded
//   - redirect_valid=1, flush=1 and redirect_pc = actual_taken ? taken_tgt : fall_tgt, for cycle N+1 only
//  Correct prediction: pop only; no redirect/flush. Latency resolve->redirect is 1 cycle; outputs are registered.
//  During the flush cycle (N+1) no push is accepted. ex_valid is honoured normally; the queue is empty, so it is ignored.
//  Back-to-back mispredicts are impossible: the queue is empty after a flush.
//  redirect_pc holds its last value when redirect_valid=0.
//  rst has priority over all events, including mid-flush: the next cycle shows reset values.
// CONFIGURATION
//  TBR_STATS_EN defined: adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
//   - each increments on every valid resolve / mispredict resolve, saturating at 16'hFFFF
//   - both reset to 0
//  TBR_STATS_EN undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset, DEPTH=4: inflight_count=0, dec_ready=1, redirect_valid=0, flush=0 -> hold for 3 cycles.
//  2. Push pc=0x0010, offset {T_NEG_ONE,T_POS_ONE}, predict=1; resolve taken=1 -> no redirect, count 1->0.
//  3. Push pc=0x0020, offset {T_POS_ONE,T_ZERO}, predict=0; resolve taken=1:
//     redirect_valid=1, flush=1, redirect_pc=0x0023 next cycle; dec_ready=0 that cycle.
//  4. Push 4 branches -> dec_ready=0 at count 4; extra push dropped.
//     Resolve head mispredicted with a same-cycle push -> count=0, push discarded.
//  5. pc=0xFFFF, offset {T_POS_ONE,T_POS_ONE}, predict=0, actual=1 -> redirect_pc=0x0003 (wrap).
//     pc=0x0001, offset {T_NEG_ONE,T_NEG_ONE}, predict=1, actual=0 -> redirect_pc=0x0002.
//  6. ex_valid with empty queue -> no change. rst mid-flush -> reset values.
//     With TBR_STATS_EN: 3 resolves, 1 mispredict -> stat_branches=3, stat_mispredicts=1.

Source files
------------

// File: rtl/ternary_branch_resolver.sv
// ternary_branch_resolver: in-flight branch queue between decode and execute.
// Each decoded branch is queued with its PC, 2-trit offset and prediction.
// Execute resolves the oldest entry. A mispredict clears the queue and sends
// a one-cycle redirect + flush to fetch.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   dec_valid/pc/offset/     branch pushed from decode (offset is balanced
//   dec_predict_taken        ternary, [1] weight 3, [0] weight 1)
//   dec_ready                queue accepts a push this cycle
//   ex_valid/actual_taken    execute resolves the head entry
//   redirect_valid/pc, flush registered one-cycle redirect to fetch
//   inflight_count           number of queued entries
//   stat_branches/           saturating resolve/mispredict counters,
//   stat_mispredicts         present only when TBR_STATS_EN is defined

package ternary_branch_resolver_pkg;
  typedef logic [1:0] trit_t;
  localparam trit_t T_ZERO    = 2'b00;
  localparam trit_t T_POS_ONE = 2'b01;
  localparam trit_t T_NEG_ONE = 2'b10;
endpackage

module ternary_branch_resolver
  import ternary_branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [PC_W-1:0]              dec_pc,
  input  trit_t [1:0]                  dec_offset,
  input  logic                         dec_predict_taken,
  output logic                         dec_ready,
  input  logic                         ex_valid,
  input  logic                         ex_actual_taken,
  output logic                         redirect_valid,
  output logic [PC_W-1:0]              redirect_pc,
  output logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_count
`ifdef TBR_STATS_EN
  ,
  output logic [15:0]                  stat_branches,
  output logic [15:0]                  stat_mispredicts
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    trit_t [1:0]     offset;
    logic            predict_taken;
  } entry_t;

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;

  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               mispredict;
  entry_t             head;
  logic signed [3:0]  off_val;
  logic signed [PC_W-1:0] off_ext;
  logic [PC_W-1:0]    taken_tgt;
  logic [PC_W-1:0]    fall_tgt;

  // Illegal encoding (2'b11) decodes as zero.
  function automatic logic signed [3:0] trit_val(input trit_t t);
    case (t)
      T_POS_ONE: trit_val = 4'sd1;
      T_NEG_ONE: trit_val = -4'sd1;
      default:   trit_val = 4'sd0;
    endcase
  endfunction

  // Queue status, handshakes and resolve targets for the head entry.
  always_comb begin
    empty      = (inflight_count == CNT_W'(0));
    full       = (inflight_count == CNT_W'(DEPTH));
    dec_ready  = !full && !flush;
    push       = dec_valid && dec_ready;
    pop        = ex_valid && !empty;
    head       = entries[rd_ptr];
    mispredict = pop && (head.predict_taken != ex_actual_taken);
    off_val    = (trit_val(head.offset[1]) * 4'sd3) + trit_val(head.offset[0]);
    off_ext    = PC_W'(off_val);
    taken_tgt  = head.pc + PC_W'(off_ext);
    fall_tgt   = head.pc + PC_W'(1);
  end

  // Entry storage; stale entries are harmless since pointers gate their use.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= '{pc: dec_pc, offset: dec_offset,
                           predict_taken: dec_predict_taken};
    end
  end

  // Pointers, occupancy and registered redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      inflight_count <= '0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= mispredict;
      flush          <= mispredict;
      if (mispredict) begin
        // Wrong path: everything younger, including a same-cycle push, dies.
        rd_ptr         <= '0;
        wr_ptr         <= '0;
        inflight_count <= '0;
        redirect_pc    <= ex_actual_taken ? taken_tgt : fall_tgt;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   inflight_count <= inflight_count + CNT_W'(1);
          2'b01:   inflight_count <= inflight_count - CNT_W'(1);
          default: inflight_count <= inflight_count;
        endcase
      end
    end
  end

`ifdef TBR_STATS_EN
  // Saturating resolve and mispredict counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop && (stat_branches != 16'hFFFF))
        stat_branches <= stat_branches + 16'd1;
      if (mispredict && (stat_mispredicts != 16'hFFFF))
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ternary_branch_resolver.sv
// Directed bench for ternary_branch_resolver (DEPTH=4, PC_W=16).
module tb_ternary_branch_resolver;
  import ternary_branch_resolver_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dec_valid = 1'b0;
  logic [15:0] dec_pc = '0;
  trit_t [1:0] dec_offset = '0;
  logic        dec_predict_taken = 1'b0;
  logic        dec_ready;
  logic        ex_valid = 1'b0;
  logic        ex_actual_taken = 1'b0;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        flush;
  logic [2:0]  inflight_count;
`ifdef TBR_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int passed = 0;
  int total  = 0;

  ternary_branch_resolver #(.DEPTH(4), .PC_W(16)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_offset(dec_offset),
    .dec_predict_taken(dec_predict_taken), .dec_ready(dec_ready),
    .ex_valid(ex_valid), .ex_actual_taken(ex_actual_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .inflight_count(inflight_count)
`ifdef TBR_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic set_push(input logic [15:0] pc, input trit_t t1, input trit_t t0,
                          input logic pred);
    dec_valid         = 1'b1;
    dec_pc            = pc;
    dec_offset        = {t1, t0};
    dec_predict_taken = pred;
  endtask

  task automatic idle();
    dec_valid = 1'b0;
    ex_valid  = 1'b0;
  endtask

  // Push one branch, then resolve it with the given outcome.
  task automatic push_resolve(input logic [15:0] pc, input trit_t t1, input trit_t t0,
                              input logic pred, input logic actual);
    set_push(pc, t1, t0, pred);
    tick();
    idle();
    ex_valid        = 1'b1;
    ex_actual_taken = actual;
    tick();
    idle();
  endtask

  initial begin
    // Reset and hold.
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_count", 32'(inflight_count), 32'd0);
      chk("rst_ready", 32'(dec_ready), 32'd1);
      chk("rst_redirect", 32'(redirect_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_rpc", 32'(redirect_pc), 32'd0);
      tick();
    end
`ifdef TBR_STATS_EN
    chk("rst_stat_br", 32'(stat_branches), 32'd0);
    chk("rst_stat_mp", 32'(stat_mispredicts), 32'd0);
`endif

    // Correct prediction: pop only.
    set_push(16'h0010, T_NEG_ONE, T_POS_ONE, 1'b1);
    tick(); idle();
    chk("t2_count1", 32'(inflight_count), 32'd1);
    ex_valid = 1'b1; ex_actual_taken = 1'b1;
    tick(); idle();
    chk("t2_count0", 32'(inflight_count), 32'd0);
    chk("t2_no_redirect", 32'(redirect_valid), 32'd0);
    chk("t2_no_flush", 32'(flush), 32'd0);

    // Mispredict, taken target pc+3.
    push_resolve(16'h0020, T_POS_ONE, T_ZERO, 1'b0, 1'b1);
    chk("t3_redirect", 32'(redirect_valid), 32'd1);
    chk("t3_flush", 32'(flush), 32'd1);
    chk("t3_rpc", 32'(redirect_pc), 32'h0023);
    chk("t3_ready_low", 32'(dec_ready), 32'd0);
    chk("t3_count", 32'(inflight_count), 32'd0);
    set_push(16'h0030, T_ZERO, T_ZERO, 1'b0);  // dropped during flush
    tick(); idle();
    chk("t3_flush_push_drop", 32'(inflight_count), 32'd0);
    chk("t3_pulse_end", 32'(redirect_valid), 32'd0);
    chk("t3_flush_end", 32'(flush), 32'd0);
    chk("t3_rpc_hold", 32'(redirect_pc), 32'h0023);
    chk("t3_ready_back", 32'(dec_ready), 32'd1);

    // Fill the queue.
    for (int i = 0; i < 4; i++) begin
      set_push(16'h0100 + 16'(4 * i), T_ZERO, T_POS_ONE, 1'b1);
      tick();
    end
    chk("t4_full_count", 32'(inflight_count), 32'd4);
    chk("t4_full_ready", 32'(dec_ready), 32'd0);
    set_push(16'h01F0, T_ZERO, T_ZERO, 1'b1);
    tick(); idle();
    chk("t4_extra_drop", 32'(inflight_count), 32'd4);
    // Pop while full: push still blocked.
    set_push(16'h01F4, T_ZERO, T_ZERO, 1'b1);
    ex_valid = 1'b1; ex_actual_taken = 1'b1;
    tick(); idle();
    chk("t4_full_no_bypass", 32'(inflight_count), 32'd3);
    // Push and pop together, not full.
    set_push(16'h0200, T_ZERO, T_ZERO, 1'b1);
    ex_valid = 1'b1; ex_actual_taken = 1'b1;
    tick(); idle();
    chk("t4_push_pop", 32'(inflight_count), 32'd3);
    chk("t4_no_redirect", 32'(redirect_valid), 32'd0);
    // Head is now 0x0108: mispredict not-taken with a same-cycle push.
    set_push(16'h0204, T_ZERO, T_ZERO, 1'b1);
    ex_valid = 1'b1; ex_actual_taken = 1'b0;
    tick(); idle();
    chk("t4_mp_redirect", 32'(redirect_valid), 32'd1);
    chk("t4_mp_rpc", 32'(redirect_pc), 32'h0109);
    chk("t4_mp_count", 32'(inflight_count), 32'd0);
    tick();
    chk("t4_push_discarded", 32'(inflight_count), 32'd0);

    // Wrap and negative offsets.
    push_resolve(16'hFFFF, T_POS_ONE, T_POS_ONE, 1'b0, 1'b1);
    chk("t5_wrap_rpc", 32'(redirect_pc), 32'h0003);
    chk("t5_wrap_redirect", 32'(redirect_valid), 32'd1);
    tick();
    push_resolve(16'h0001, T_NEG_ONE, T_NEG_ONE, 1'b1, 1'b0);
    chk("t5_fall_rpc", 32'(redirect_pc), 32'h0002);
    tick();
    push_resolve(16'h0001, T_NEG_ONE, T_NEG_ONE, 1'b0, 1'b1);
    chk("t5_neg_wrap_rpc", 32'(redirect_pc), 32'hFFFD);
    tick();
    push_resolve(16'h0050, T_POS_ONE, trit_t'(2'b11), 1'b0, 1'b1);
    chk("t5_illegal_trit", 32'(redirect_pc), 32'h0053);
    tick();

    // Resolve with empty queue.
    ex_valid = 1'b1; ex_actual_taken = 1'b0;
    tick(); idle();
    chk("t6_empty_count", 32'(inflight_count), 32'd0);
    chk("t6_empty_redirect", 32'(redirect_valid), 32'd0);
    chk("t6_empty_rpc", 32'(redirect_pc), 32'h0053);

    // Reset during flush.
    push_resolve(16'h0300, T_ZERO, T_POS_ONE, 1'b0, 1'b1);
    chk("t6_pre_rst_redirect", 32'(redirect_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_redirect", 32'(redirect_valid), 32'd0);
    chk("t6_rst_flush", 32'(flush), 32'd0);
    chk("t6_rst_rpc", 32'(redirect_pc), 32'd0);
    chk("t6_rst_count", 32'(inflight_count), 32'd0);
    chk("t6_rst_ready", 32'(dec_ready), 32'd1);

`ifdef TBR_STATS_EN
    for (int i = 0; i < 3; i++) begin
      set_push(16'h0400 + 16'(i), T_ZERO, T_ZERO, 1'b1);
      tick();
    end
    idle();
    ex_valid = 1'b1; ex_actual_taken = 1'b1;
    tick(); tick();
    ex_actual_taken = 1'b0;
    tick(); idle();
    chk("stat_branches", 32'(stat_branches), 32'd3);
    chk("stat_mispredicts", 32'(stat_mispredicts), 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
